tx_desc_fetch: RTL and testbench

TX_DESC_FETCH -- requirements
Module: tx_desc_fetch

---
 rtl/tx_desc_fetch_if.sv | 44 ++++
 rtl/tx_desc_fetch.sv | 172 +++++++++++++++++
 tb/tb_tx_desc_fetch.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_desc_fetch_if.sv
// Bus bundle for the TX descriptor fetcher: primary-controller control,
// memory read port, downstream hand-off and debug state.
interface tx_desc_fetch_if;
    // Primary controller
    logic        pcTrigTxListProc;
    logic [31:0] pcStatusPtr;
    logic        trigTxPCHalt_p;
    logic        trigTxPCDead_p;
    logic        updPCStaPtr_p;
    logic [31:0] nxtDescPtr;
    // Memory read port
    logic        rdReq;
    logic [31:0] rdAddr;
    logic        rdGrant;
    logic        rdDataValid;
    logic [31:0] rdData;
    logic        rdError;
    // Downstream frame hand-off
    logic        descValid;
    logic [31:0] dataStartPtr;
    logic [31:0] dataEndPtr;
    logic [15:0] frameLen;
    logic        descDone_p;
    // Debug
    logic [2:0]  descFetchState;

    // Fetch engine side
    modport master (
        input  pcTrigTxListProc, pcStatusPtr, rdGrant, rdDataValid, rdData,
               rdError, descDone_p,
        output trigTxPCHalt_p, trigTxPCDead_p, updPCStaPtr_p, nxtDescPtr,
               rdReq, rdAddr, descValid, dataStartPtr, dataEndPtr, frameLen,
               descFetchState
    );

    // Controller / memory / consumer side
    modport slave (
        output pcTrigTxListProc, pcStatusPtr, rdGrant, rdDataValid, rdData,
               rdError, descDone_p,
        input  trigTxPCHalt_p, trigTxPCDead_p, updPCStaPtr_p, nxtDescPtr,
               rdReq, rdAddr, descValid, dataStartPtr, dataEndPtr, frameLen,
               descFetchState
    );
endinterface

// File: rtl/tx_desc_fetch.sv
// TX descriptor fetcher: reads a 4-word descriptor one beat at a time,
// validates it, hands the frame window downstream and reports the next
// descriptor pointer (or halt / fatal error) to the primary controller.
module tx_desc_fetch (
    input  logic             macPITxClk,
    input  logic             macPITxClkHardRst_n,
    input  logic             macPITxClkSoftRst_n,
    tx_desc_fetch_if.master  desc_if
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_HANDOFF = 3'd4;
    localparam logic [2:0] S_UPDATE  = 3'd5;
    localparam logic [2:0] S_DEAD    = 3'd6;

    localparam logic [31:0] DESC_PATTERN = 32'hCAFE_BABE;

    logic [2:0]  r_state;
    logic [31:0] r_base;
    logic [1:0]  r_word_cnt;
    logic        r_abort;
    logic [31:0] r_rd_addr;
    logic [31:0] r_w0, r_w1, r_w2, r_w3;
    logic [15:0] r_frame_len;
    logic [31:0] r_nxt_desc_ptr;
    logic        r_upd_p, r_halt_p, r_dead_p;

    logic        w_ptr_ok;
    logic [1:0]  w_next_cnt;
    logic [31:0] w_next_addr;
    logic [31:0] w_diff;
    logic        w_desc_bad;

    // Pointer validation, next beat address and descriptor sanity checks
    always_comb begin
        // NOTE: every always_comb output gets a value on every path so no latch is inferred.
        w_ptr_ok    = (desc_if.pcStatusPtr[1:0] == 2'b00) && (desc_if.pcStatusPtr[31:2] != 30'd0);
        w_next_cnt  = r_word_cnt + 2'd1;
        w_next_addr = r_base + {28'd0, w_next_cnt, 2'b00};
        w_diff      = r_w3 - r_w2;
        w_desc_bad  = (r_w0 != DESC_PATTERN) || (r_w3 < r_w2) || (w_diff > 32'h0000_FFFE);
    end

    // Fetch FSM with hard (async) and soft (sync, highest priority) reset
    always_ff @(posedge macPITxClk or negedge macPITxClkHardRst_n) begin
        if (!macPITxClkHardRst_n) begin
            r_state        <= S_IDLE;
            r_base         <= 32'h0;
            r_word_cnt     <= 2'd0;
            r_abort        <= 1'b0;
            r_rd_addr      <= 32'h0;
            // NOTE: descriptor words are reset because two of them drive dataStartPtr/dataEndPtr directly.
            r_w0           <= 32'h0;
            r_w1           <= 32'h0;
            r_w2           <= 32'h0;
            r_w3           <= 32'h0;
            r_frame_len    <= 16'h0;
            r_nxt_desc_ptr <= 32'h0;
            r_upd_p        <= 1'b0;
            r_halt_p       <= 1'b0;
            r_dead_p       <= 1'b0;
        end else if (!macPITxClkSoftRst_n) begin
            r_state        <= S_IDLE;
            r_base         <= 32'h0;
            r_word_cnt     <= 2'd0;
            r_abort        <= 1'b0;
            r_rd_addr      <= 32'h0;
            r_w0           <= 32'h0;
            r_w1           <= 32'h0;
            r_w2           <= 32'h0;
            r_w3           <= 32'h0;
            r_frame_len    <= 16'h0;
            r_nxt_desc_ptr <= 32'h0;
            r_upd_p        <= 1'b0;
            r_halt_p       <= 1'b0;
            r_dead_p       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_upd_p  <= 1'b0;
            r_halt_p <= 1'b0;
            r_dead_p <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (desc_if.pcTrigTxListProc) begin
                        if (w_ptr_ok) begin
                            r_base     <= desc_if.pcStatusPtr;
                            r_rd_addr  <= desc_if.pcStatusPtr;
                            r_word_cnt <= 2'd0;
                            r_abort    <= 1'b0;
                            r_state    <= S_REQ;
                        end else begin
                            r_dead_p <= 1'b1;
                            r_state  <= S_DEAD;
                        end
                    end
                end
                S_REQ: begin
                    // Once granted the beat must complete; before that it may be withdrawn.
                    if (desc_if.rdGrant) begin
                        r_abort <= !desc_if.pcTrigTxListProc;
                        r_state <= S_WAIT;
                    end else if (!desc_if.pcTrigTxListProc) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!desc_if.pcTrigTxListProc) begin
                        r_abort <= 1'b1;
                    end
                    if (desc_if.rdDataValid) begin
                        if (desc_if.rdError) begin
                            r_dead_p <= 1'b1;
                            r_state  <= S_DEAD;
                        end else begin
                            case (r_word_cnt)
                                2'd0:    r_w0 <= desc_if.rdData;
                                2'd1:    r_w1 <= desc_if.rdData;
                                2'd2:    r_w2 <= desc_if.rdData;
                                default: r_w3 <= desc_if.rdData;
                            endcase
                            if (r_abort || !desc_if.pcTrigTxListProc) begin
                                r_state <= S_IDLE;
                            end else if (r_word_cnt != 2'd3) begin
                                r_word_cnt <= w_next_cnt;
                                r_rd_addr  <= w_next_addr;
                                r_state    <= S_REQ;
                            end else begin
                                r_state <= S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (w_desc_bad) begin
                        r_dead_p <= 1'b1;
                        r_state  <= S_DEAD;
                    end else begin
                        r_frame_len <= w_diff[15:0] + 16'd1;
                        r_state     <= S_HANDOFF;
                    end
                end
                S_HANDOFF: begin
                    if (desc_if.descDone_p) begin
                        r_nxt_desc_ptr <= r_w1;
                        r_upd_p        <= 1'b1;
                        r_halt_p       <= (r_w1 == 32'h0);
                        r_state        <= S_UPDATE;
                    end
                end
                S_UPDATE: r_state <= S_IDLE;
                S_DEAD:   r_state <= S_DEAD;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign desc_if.rdReq          = (r_state == S_REQ);
    assign desc_if.rdAddr         = r_rd_addr;
    assign desc_if.descValid      = (r_state == S_HANDOFF);
    assign desc_if.dataStartPtr   = r_w2;
    assign desc_if.dataEndPtr     = r_w3;
    assign desc_if.frameLen       = r_frame_len;
    assign desc_if.nxtDescPtr     = r_nxt_desc_ptr;
    assign desc_if.updPCStaPtr_p  = r_upd_p;
    assign desc_if.trigTxPCHalt_p = r_halt_p;
    assign desc_if.trigTxPCDead_p = r_dead_p;
    assign desc_if.descFetchState = r_state;

endmodule

// File: tb/tb_tx_desc_fetch.sv
// Directed bench for tx_desc_fetch: memory responder with programmable
// grant delay / error beat, pulse monitor, and hand-computed expectations.
module tb_tx_desc_fetch;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_HANDOFF = 3'd4;
    localparam logic [2:0] S_UPDATE  = 3'd5;
    localparam logic [2:0] S_DEAD    = 3'd6;

    logic clk;
    logic hard_rst_n;
    logic soft_rst_n;

    tx_desc_fetch_if dif ();

    tx_desc_fetch dut (
        .macPITxClk          (clk),
        .macPITxClkHardRst_n (hard_rst_n),
        .macPITxClkSoftRst_n (soft_rst_n),
        .desc_if             (dif)
    );

    int checks   = 0;
    int failures = 0;

    // Responder knobs (written by the main sequence)
    logic [31:0] tb_base     = 32'h0;
    logic [31:0] mem [4];
    int          grant_delay = 0;
    int          err_word    = -1;

    // Responder observations
    logic [31:0] addr_log [$];
    int          addr_moves = 0;

    // Monitor observations
    int rdreq_cycles = 0;
    int desc_cycles  = 0;
    int upd_cnt      = 0;
    int wide_pulses  = 0;
    int halt_and_dead = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Memory responder: grants after grant_delay waiting cycles, data two cycles after grant
    initial begin
        bit          pend = 0;
        bit          hold = 0;
        int          lat = 0;
        int          wait_cnt = 0;
        int          idx;
        logic [31:0] pend_addr = 32'h0;
        logic [31:0] hold_addr = 32'h0;
        dif.rdGrant = 1'b0; dif.rdDataValid = 1'b0; dif.rdData = 32'h0; dif.rdError = 1'b0;
        forever begin
            @(negedge clk);
            dif.rdGrant = 1'b0; dif.rdDataValid = 1'b0; dif.rdData = 32'h0; dif.rdError = 1'b0;
            if (pend) begin
                if (lat == 1) begin
                    idx = int'((pend_addr - tb_base) >> 2);
                    dif.rdDataValid = 1'b1;
                    dif.rdData      = mem[idx[1:0]];
                    dif.rdError     = (idx == err_word);
                    pend = 0;
                end else begin
                    lat--;
                end
            end else if (dif.rdReq === 1'b1) begin
                if (hold && dif.rdAddr !== hold_addr) addr_moves++;
                hold = 1; hold_addr = dif.rdAddr;
                if (wait_cnt >= grant_delay) begin
                    dif.rdGrant = 1'b1;
                    pend = 1; lat = 2; pend_addr = dif.rdAddr;
                    addr_log.push_back(dif.rdAddr);
                    wait_cnt = 0; hold = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0; hold = 0;
            end
        end
    end

    // Pulse / activity monitor
    initial begin
        logic p_dead = 0, p_halt = 0, p_upd = 0;
        forever begin
            @(negedge clk);
            if (dif.rdReq === 1'b1) rdreq_cycles++;
            if (dif.descValid === 1'b1) desc_cycles++;
            if (dif.updPCStaPtr_p === 1'b1) upd_cnt++;
            if ((dif.trigTxPCDead_p && p_dead) || (dif.trigTxPCHalt_p && p_halt) ||
                (dif.updPCStaPtr_p && p_upd)) wide_pulses++;
            if (dif.trigTxPCDead_p && dif.trigTxPCHalt_p) halt_and_dead++;
            p_dead = dif.trigTxPCDead_p; p_halt = dif.trigTxPCHalt_p; p_upd = dif.updPCStaPtr_p;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int k = 0;
        while (dif.descFetchState !== s && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {29'd0, dif.descFetchState}, {29'd0, s});
    endtask

    task automatic load_desc(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        tb_base = base;
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    endtask

    task automatic start(input logic [31:0] ptr);
        dif.pcStatusPtr      = ptr;
        dif.pcTrigTxListProc = 1'b1;
    endtask

    task automatic done_pulse();
        dif.descDone_p = 1'b1;
        @(negedge clk);
        dif.descDone_p = 1'b0;
    endtask

    task automatic soft_reset();
        dif.pcTrigTxListProc = 1'b0;
        soft_rst_n = 1'b0;
        tick(1);
        soft_rst_n = 1'b1;
        check("soft_reset_idle", {29'd0, dif.descFetchState}, {29'd0, S_IDLE});
    endtask

    initial begin
        int n0, rq0, d0, u0, m0;
        hard_rst_n = 1'b0; soft_rst_n = 1'b1;
        dif.pcTrigTxListProc = 1'b0; dif.pcStatusPtr = 32'h0; dif.descDone_p = 1'b0;
        load_desc(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(2);

        // Reset values
        check("rst_state",  {29'd0, dif.descFetchState}, {29'd0, S_IDLE});
        check("rst_rdreq",  {31'd0, dif.rdReq}, 32'd0);
        check("rst_valid",  {31'd0, dif.descValid}, 32'd0);
        check("rst_rdaddr", dif.rdAddr, 32'h0);
        check("rst_nxt",    dif.nxtDescPtr, 32'h0);
        check("rst_start",  dif.dataStartPtr, 32'h0);
        check("rst_end",    dif.dataEndPtr, 32'h0);
        check("rst_len",    {16'd0, dif.frameLen}, 32'h0);
        check("rst_pulses", {29'd0, dif.trigTxPCDead_p, dif.trigTxPCHalt_p, dif.updPCStaPtr_p}, 32'd0);
        hard_rst_n = 1'b1;
        tick(1);

        // Normal fetch, 0x1000 -> next 0x2000
        u0 = upd_cnt;
        load_desc(32'h1000, 32'hCAFEBABE, 32'h2000, 32'h4000, 32'h40FF);
        n0 = addr_log.size();
        start(32'h1000);
        wait_state("t1_handoff", S_HANDOFF, 60);
        check("t1_nreads", addr_log.size() - n0, 4);
        check("t1_addr0", addr_log[n0],   32'h1000);
        check("t1_addr1", addr_log[n0+1], 32'h1004);
        check("t1_addr2", addr_log[n0+2], 32'h1008);
        check("t1_addr3", addr_log[n0+3], 32'h100C);
        check("t1_valid", {31'd0, dif.descValid}, 32'd1);
        check("t1_len",   {16'd0, dif.frameLen}, 32'h0100);
        check("t1_start", dif.dataStartPtr, 32'h4000);
        check("t1_end",   dif.dataEndPtr, 32'h40FF);
        tick(3);
        check("t1_valid_hold", {31'd0, dif.descValid}, 32'd1);
        check("t1_len_hold",   {16'd0, dif.frameLen}, 32'h0100);
        done_pulse();
        check("t1_upd",   {31'd0, dif.updPCStaPtr_p}, 32'd1);
        check("t1_nxt",   dif.nxtDescPtr, 32'h2000);
        check("t1_halt",  {31'd0, dif.trigTxPCHalt_p}, 32'd0);
        check("t1_valid_drop", {31'd0, dif.descValid}, 32'd0);

        // Back-to-back with controller-updated pointer; w1=0 ends the list
        dif.pcStatusPtr = 32'h2000;
        load_desc(32'h2000, 32'hCAFEBABE, 32'h0, 32'h100, 32'h100);
        tick(1);
        check("t2_idle", {29'd0, dif.descFetchState}, {29'd0, S_IDLE});
        tick(1);
        check("t2_req",  {29'd0, dif.descFetchState}, {29'd0, S_REQ});
        check("t2_addr", dif.rdAddr, 32'h2000);
        wait_state("t2_handoff", S_HANDOFF, 60);
        check("t2_len",  {16'd0, dif.frameLen}, 32'h0001);
        done_pulse();
        check("t2_upd",  {31'd0, dif.updPCStaPtr_p}, 32'd1);
        check("t2_halt", {31'd0, dif.trigTxPCHalt_p}, 32'd1);
        check("t2_dead", {31'd0, dif.trigTxPCDead_p}, 32'd0);
        check("t2_nxt",  dif.nxtDescPtr, 32'h0);
        dif.pcTrigTxListProc = 1'b0;
        tick(1);
        check("t2_end_idle", {29'd0, dif.descFetchState}, {29'd0, S_IDLE});
        dif.descDone_p = 1'b1;
        tick(1);
        dif.descDone_p = 1'b0;
        tick(2);
        check("t2_stray_done_state", {29'd0, dif.descFetchState}, {29'd0, S_IDLE});
        check("t2_upd_count", upd_cnt - u0, 2);

        // Bad pattern -> dead one cycle after the last beat
        d0 = desc_cycles;
        load_desc(32'h3000, 32'hDEADBEEF, 32'h3100, 32'h3200, 32'h32FF);
        start(32'h3000);
        wait_state("t3_check", S_CHECK, 60);
        check("t3_no_dead_yet", {31'd0, dif.trigTxPCDead_p}, 32'd0);
        tick(1);
        check("t3_dead_state", {29'd0, dif.descFetchState}, {29'd0, S_DEAD});
        check("t3_dead_p", {31'd0, dif.trigTxPCDead_p}, 32'd1);
        tick(1);
        check("t3_dead_p_width", {31'd0, dif.trigTxPCDead_p}, 32'd0);
        rq0 = rdreq_cycles;
        tick(5);
        check("t3_no_req_dead", rdreq_cycles - rq0, 0);
        check("t3_no_valid", desc_cycles - d0, 0);
        check("t3_stay_dead", {29'd0, dif.descFetchState}, {29'd0, S_DEAD});
        soft_reset();

        // Misaligned pointer -> dead next cycle, no request
        rq0 = rdreq_cycles;
        start(32'h1002);
        tick(1);
        check("t4_dead_p", {31'd0, dif.trigTxPCDead_p}, 32'd1);
        check("t4_dead_state", {29'd0, dif.descFetchState}, {29'd0, S_DEAD});
        tick(4);
        check("t4_no_req", rdreq_cycles - rq0, 0);
        dif.pcTrigTxListProc = 1'b0;
        hard_rst_n = 1'b0;
        #1;
        check("t4_hard_rst_idle", {29'd0, dif.descFetchState}, {29'd0, S_IDLE});
        tick(1);
        hard_rst_n = 1'b1;
        tick(1);

        // Slow grant, trigger dropped while word 1 is outstanding
        load_desc(32'h5000, 32'hCAFEBABE, 32'h5100, 32'h5200, 32'h52FF);
        grant_delay = 5;
        n0 = addr_log.size(); rq0 = rdreq_cycles; d0 = desc_cycles; u0 = upd_cnt; m0 = addr_moves;
        start(32'h5000);
        begin
            int k = 0;
            while (!(dif.descFetchState === S_WAIT && dif.rdAddr === 32'h5004) && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        check("t5_wait_w1", dif.rdAddr, 32'h5004);
        dif.pcTrigTxListProc = 1'b0;
        wait_state("t5_idle", S_IDLE, 40);
        tick(2);
        check("t5_nreads",  addr_log.size() - n0, 2);
        check("t5_addr1",   addr_log[n0+1], 32'h5004);
        check("t5_stable",  addr_moves - m0, 0);
        check("t5_req_cyc", rdreq_cycles - rq0, 12);
        check("t5_no_valid", desc_cycles - d0, 0);
        check("t5_no_upd",  upd_cnt - u0, 0);
        grant_delay = 0;

        // Read error on word 2
        load_desc(32'h6000, 32'hCAFEBABE, 32'h6100, 32'h6200, 32'h62FF);
        err_word = 2;
        n0 = addr_log.size();
        start(32'h6000);
        wait_state("t6_dead", S_DEAD, 60);
        check("t6_dead_p", {31'd0, dif.trigTxPCDead_p}, 32'd1);
        check("t6_nreads", addr_log.size() - n0, 3);
        err_word = -1;
        soft_reset();

        // End pointer below start pointer
        load_desc(32'h7000, 32'hCAFEBABE, 32'h7100, 32'h0500, 32'h04FF);
        start(32'h7000);
        wait_state("t7_check", S_CHECK, 60);
        tick(1);
        check("t7_dead_state", {29'd0, dif.descFetchState}, {29'd0, S_DEAD});
        check("t7_dead_p", {31'd0, dif.trigTxPCDead_p}, 32'd1);
        soft_reset();

        // Largest legal span; trigger drop does not abort hand-off
        load_desc(32'h8000, 32'hCAFEBABE, 32'h8100, 32'h0001_0000, 32'h0001_FFFE);
        start(32'h8000);
        wait_state("t8_handoff", S_HANDOFF, 60);
        check("t8_len", {16'd0, dif.frameLen}, 32'hFFFF);
        dif.pcTrigTxListProc = 1'b0;
        tick(2);
        check("t8_hold_state", {29'd0, dif.descFetchState}, {29'd0, S_HANDOFF});
        check("t8_hold_valid", {31'd0, dif.descValid}, 32'd1);
        done_pulse();
        check("t8_upd", {31'd0, dif.updPCStaPtr_p}, 32'd1);
        check("t8_nxt", dif.nxtDescPtr, 32'h8100);
        tick(1);

        // Span one past the limit
        load_desc(32'h9000, 32'hCAFEBABE, 32'h9100, 32'h0001_0000, 32'h0001_FFFF);
        start(32'h9000);
        wait_state("t9_check", S_CHECK, 60);
        tick(1);
        check("t9_dead_state", {29'd0, dif.descFetchState}, {29'd0, S_DEAD});
        soft_reset();

        // Soft reset with a beat outstanding; late data ignored
        load_desc(32'hA000, 32'hCAFEBABE, 32'hA100, 32'hA200, 32'hA2FF);
        n0 = addr_log.size();
        start(32'hA000);
        wait_state("t10_wait", S_WAIT, 20);
        soft_reset();
        check("t10_rdreq", {31'd0, dif.rdReq}, 32'd0);
        tick(4);
        check("t10_still_idle", {29'd0, dif.descFetchState}, {29'd0, S_IDLE});
        check("t10_nreads", addr_log.size() - n0, 1);

        check("pulse_width", wide_pulses, 0);
        check("halt_dead_excl", halt_and_dead, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
